fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
- Single-clock, parametrised FIFO; successor to the dual-clock 8-bit/256-entry FIFO.
- Generalised data width and depth, with a fill-level counter, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Used wherever producer and consumer share one clock: stream buffering between pipeline stages and UVM-testable datapath glue.
- Optional first-word-fall-through read mode.

Parameters:
- DW, 8, data width in bits.
- AW, 8, address width; depth = 2**AW entries.
- AF_LVL, 2**AW-2, almost-full asserts when fill count >= AF_LVL.
- AE_LVL, 2, almost-empty asserts when fill count <= AE_LVL.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- WREQ  input  1  write request.
- WD  input  DW  write data.
- RREQ  input  1  read request.
- RD  output  DW  read data.
- f  output  1  full.
- e  output  1  empty.
- af  output  1  almost full.
- ae  output  1  almost empty.
- CNT  output  AW+1  current fill count, 0..2**AW.
- ovf  output  1  sticky overflow: a write was attempted while full.
- udf  output  1  sticky underflow: a read was attempted while empty.
- clr_err  input  1  synchronous clear of ovf and udf.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately regardless of clk):
  - wptr=rptr=0, CNT=0, e=1, f=0, ae=1, af=0, ovf=0, udf=0, RD=0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored data. After release, the first accepted write is read back first.
- Pointers: wptr and rptr are AW+1 bits; low AW bits address memory; the MSB is the wrap bit. Pointers wrap naturally modulo 2**(AW+1).
- f = (wptr[AW-1:0]==rptr[AW-1:0]) && (wptr[AW]!=rptr[AW]).
- e = (wptr==rptr).
- CNT = wptr - rptr, computed modulo 2**(AW+1).
- af = (CNT >= AF_LVL); ae = (CNT <= AE_LVL).
- All flags derive from registered pointers and are glitch-free after each clk edge.
- Write acceptance: wr_ok = WREQ && !f. On posedge: mem[wptr[AW-1:0]] <= WD and wptr <= wptr+1.
- Read acceptance: rd_ok = RREQ && !e. On posedge: rptr <= rptr+1.
- Simultaneous events:
  - wr_ok and rd_ok both true: both happen; CNT unchanged.
  - Full with WREQ and RREQ: only the read is accepted; CNT decrements by 1; ovf is set.
  - Empty with WREQ and RREQ: only the write is accepted; CNT becomes 1; udf is set.
- Standard read mode (FWFT_EN undefined):
  - On a rd_ok edge, RD <= mem[rptr[AW-1:0]]; data is valid from that edge, i.e. one-cycle latency from RREQ.
  - RD holds its value when no read is accepted.
- Error flags, evaluated on posedge:
  - ovf <= 1 when WREQ && f; udf <= 1 when RREQ && e.
  - clr_err=1 clears both flags. If clr_err and a new error occur in the same cycle, set wins.
- Rejected requests (full write, empty read) change no pointer and no memory.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- When defined, RD is driven combinationally as mem[rptr[AW-1:0]]:
  - The head word is visible whenever e=0, with no request.
  - RREQ acts as a pop/acknowledge; after the pop edge RD shows the next word.
  - A word written into an empty FIFO appears on RD in the cycle after the write edge, together with e going low.
  - RD is undefined and must be ignored while e=1.
- When undefined, the standard registered-read behaviour above applies.

Test Plan (DW=8, AW=2, AF_LVL=3, AE_LVL=1):
- Reset: drive rst=0 asynchronously mid-clock → e=1, f=0, ae=1, af=0, CNT=0, ovf=udf=0, RD=0 immediately, without waiting for a clk edge.
- Fill: 4 writes of 0x11, 0x22, 0x33, 0x44 →
  - CNT steps 1, 2, 3, 4.
  - ae drops after the 2nd write; af rises after the 3rd; f rises after the 4th.
  - A 5th write of 0x55 is rejected and ovf=1; CNT stays 4.
- Drain (standard mode): 4 reads → RD = 0x11, 0x22, 0x33, 0x44, each one cycle after its RREQ. e=1 after the 4th read. A 5th read sets udf=1 and RD holds 0x44.
- Wrap/simultaneous: write 3 words, then 10 cycles with WREQ=RREQ=1 and incrementing data →
  - CNT stays at 3 and the output sequence is in order across the pointer wrap.
  - Full with both requests → CNT drops by 1, ovf=1.
  - Empty with both requests → CNT becomes 1, udf=1.
- Error clear: with ovf=1, pulse clr_err → ovf=0 next cycle. Repeat with clr_err and WREQ&&f in the same cycle → ovf stays 1.
- FWFT build (FIFO_FWFT_EN): write 0xA5 into an empty FIFO → next cycle e=0 and RD=0xA5 with no RREQ. Pop → e=1.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if -- handshake/status bundle for fifo_sync_param.
//   master : producer/consumer side. It drives WREQ, WD, RREQ and clr_err,
//            and observes RD, the status flags, CNT and the error flags.
//   slave  : the FIFO itself.
// Parameters DW/AW must match those of the fifo_sync_param instance.
interface fifo_sync_param_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          WREQ;
    logic [DW-1:0] WD;
    logic          RREQ;
    logic [DW-1:0] RD;
    logic          f;
    logic          e;
    logic          af;
    logic          ae;
    logic [AW:0]   CNT;
    logic          ovf;
    logic          udf;
    logic          clr_err;

    modport master (
        output WREQ, WD, RREQ, clr_err,
        input  RD, f, e, af, ae, CNT, ovf, udf
    );

    modport slave (
        input  WREQ, WD, RREQ, clr_err,
        output RD, f, e, af, ae, CNT, ovf, udf
    );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param -- single-clock parametrised FIFO, depth 2**AW words of DW bits.
// Ports:
//   clk  : single clock, all state changes on posedge
//   rst  : asynchronous active-low reset (pointers, flags, RD; memory not reset)
//   bus  : fifo_sync_param_if.slave
//          WREQ/WD write, RREQ read, RD read data, f/e full/empty,
//          af/ae almost-full (CNT>=AF_LVL) / almost-empty (CNT<=AE_LVL),
//          CNT fill level, ovf/udf sticky error flags, clr_err clears them.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads
// (RD shows the head word combinationally; RREQ pops). Without it RD is
// registered and is loaded on each accepted read.
module fifo_sync_param #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int AF_LVL = (2**AW) - 2,
    parameter int AE_LVL = 2
) (
    input  logic               clk,
    input  logic               rst,
    fifo_sync_param_if.slave   bus
);
    localparam int          DEPTH = 2**AW;
    localparam logic [AW:0] ONE_C = (AW+1)'(1);
    localparam logic [AW:0] AF_C  = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_C  = (AW+1)'(AE_LVL);

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] cnt_q,  cnt_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        af_q,   af_d;
    logic        ae_q,   ae_d;
    logic        ovf_q,  ovf_d;
    logic        udf_q,  udf_d;
    logic        wr_ok_s;
    logic        rd_ok_s;
`ifndef FIFO_FWFT_EN
    logic [DW-1:0] rd_q, rd_d;
`endif

    // Acceptance, next pointers, and flags decoded from the next pointers so
    // the flags come straight out of flops (glitch-free after each edge).
    always_comb begin
        wr_ok_s = bus.WREQ && !full_q;
        rd_ok_s = bus.RREQ && !empty_q;

        if (wr_ok_s) begin
            wptr_d = wptr_q + ONE_C;
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_ok_s) begin
            rptr_d = rptr_q + ONE_C;
        end else begin
            rptr_d = rptr_q;
        end

        // Subtraction wraps modulo 2**(AW+1), so the wrap bit makes 0..DEPTH exact.
        cnt_d   = wptr_d - rptr_d;
        full_d  = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
        empty_d = (wptr_d == rptr_d);
        af_d    = (cnt_d >= AF_C);
        ae_d    = (cnt_d <= AE_C);

        // A new error in the same cycle as clr_err keeps the flag set.
        if (bus.WREQ && full_q) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (bus.RREQ && empty_q) begin
            udf_d = 1'b1;
        end else if (bus.clr_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

`ifndef FIFO_FWFT_EN
    // Registered read data: load the head word on an accepted read, else hold.
    always_comb begin
        if (rd_ok_s) begin
            rd_d = mem_q[rptr_q[AW-1:0]];
        end else begin
            rd_d = rd_q;
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q <= {DW{1'b0}};
        end else begin
            rd_q <= rd_d;
        end
    end

    assign bus.RD = rd_q;
`else
    // Head word visible without a request; meaningless while empty.
    assign bus.RD = mem_q[rptr_q[AW-1:0]];
`endif

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= {(AW+1){1'b0}};
            rptr_q  <= {(AW+1){1'b0}};
            cnt_q   <= {(AW+1){1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; deliberately not reset, stale words are unreachable
    // because the pointers restart together.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wptr_q[AW-1:0]] <= bus.WD;
        end
    end

    assign bus.f   = full_q;
    assign bus.e   = empty_q;
    assign bus.af  = af_q;
    assign bus.ae  = ae_q;
    assign bus.CNT = cnt_q;
    assign bus.ovf = ovf_q;
    assign bus.udf = udf_q;
endmodule
